// File: rtl/insn_encoder_pkg.sv
// Shared definitions for the instruction encoder: field widths, type/opcode codes,
// FSM state encoding and the instruction field bundle.
package insn_encoder_pkg;

  localparam int unsigned TYPE_W = 2;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned IMM_W  = 5;
  localparam int unsigned WORD_W = 9;

  localparam logic [TYPE_W-1:0] TYPE_I   = 2'd0;
  localparam logic [TYPE_W-1:0] TYPE_II  = 2'd1;
  localparam logic [TYPE_W-1:0] TYPE_III = 2'd2;
  localparam logic [TYPE_W-1:0] TYPE_IV  = 2'd3;

  // typeI opcode that terminates a program load
  localparam logic [OP_W-1:0] I_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

  typedef struct packed {
    logic [TYPE_W-1:0] typ;
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rg;
    logic [IMM_W-1:0]  imm;
  } insn_fields_t;

endpackage

// File: rtl/insn_encoder_if.sv
// Instruction-field input handshake plus memory write port and load status.
interface insn_encoder_if #(
  parameter int unsigned ADDR_W = 8
);
  import insn_encoder_pkg::*;

  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [TYPE_W-1:0] in_type;
  logic [OP_W-1:0]   in_op;
  logic [REG_W-1:0]  in_reg;
  logic [IMM_W-1:0]  in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              done;
  logic [ADDR_W:0]   count;
  logic              err;

  modport master (
    output start, in_valid, in_type, in_op, in_reg, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, done, count, err
  );

  modport slave (
    input  start, in_valid, in_type, in_op, in_reg, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata, done, count, err
  );

endinterface

// File: rtl/insn_encoder_pack.sv
// Combinational field-to-word packing; with ENC_RANGE_CHECK_EN defined it also flags
// beats whose unused field bits are nonzero.
module insn_pack
  import insn_encoder_pkg::*;
(
  input  insn_fields_t      i_fields,
  output logic [WORD_W-1:0] o_word_c,
  output logic              o_err_c
);

  always_comb begin
    o_word_c = '0;
    case (i_fields.typ)
      TYPE_I:           o_word_c = {i_fields.typ, i_fields.op, i_fields.rg};
      TYPE_III:         o_word_c = {i_fields.typ, i_fields.op[1:0], i_fields.imm};
      TYPE_II, TYPE_IV: o_word_c = {i_fields.typ, i_fields.op[0], i_fields.imm[2:0], i_fields.rg};
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Any bit the chosen layout discards must be zero
  always_comb begin
    o_err_c = 1'b0;
    case (i_fields.typ)
      TYPE_I:           o_err_c = |i_fields.imm;
      TYPE_III:         o_err_c = (|i_fields.op[3:2]) | (|i_fields.rg);
      TYPE_II, TYPE_IV: o_err_c = (|i_fields.op[3:1]) | (|i_fields.imm[4:3]);
    endcase
  end
`else
  assign o_err_c = 1'b0;
`endif

endmodule

// File: rtl/insn_encoder.sv
// Program loader: packs accepted instruction beats and writes them to sequential
// memory addresses until HALT or full. Optional field checking via ENC_RANGE_CHECK_EN.
module insn_encoder
  import insn_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input logic           i_clk,
  input logic           i_rst,
  insn_encoder_if.slave bus
);

  enc_state_e        r_state;
  logic              r_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [ADDR_W:0]   r_count;
  logic              r_done;
  logic              r_err;

  insn_fields_t      w_fields;
  logic [WORD_W-1:0] w_word;
  logic              w_bad;
  logic              w_accept;
  logic              w_halt;
  logic              w_last;

  assign w_fields = {bus.in_type, bus.in_op, bus.in_reg, bus.in_imm};

  insn_pack u_pack (
    .i_fields (w_fields),
    .o_word_c (w_word),
    .o_err_c  (w_bad)
  );

  assign w_accept = bus.in_valid & r_ready;
  assign w_halt   = (bus.in_type == TYPE_I) && (bus.in_op == I_HALT);
  // Count equals the write pointer while loading, so its low bits address memory
  assign w_last   = (r_count[ADDR_W-1:0] == {ADDR_W{1'b1}});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state <= ST_LOAD;
            r_ready <= 1'b1;
            r_count <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        ST_LOAD: begin
          // Start restarts the load and drops a simultaneous beat
          if (bus.start) begin
            r_count <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end else if (w_accept) begin
            if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              r_we    <= 1'b1;
              r_addr  <= r_count[ADDR_W-1:0];
              r_wdata <= w_word;
              r_count <= r_count + (ADDR_W+1)'(1);
              if (w_halt || w_last) begin
                r_state <= ST_DONE;
                r_ready <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_ready;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.count     = r_count;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_insn_encoder.sv
// Self-checking bench for insn_encoder: directed vector table, a small-memory fill
// sequence, and randomized traffic against a behavioural model (two instances).
module tb_insn_encoder;
  import insn_encoder_pkg::*;

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    int rst, start, valid, typ, op, rg, imm;
    int we, addr, wdata, cnt, done, rdy, err;
  } vec_t;

  typedef struct {
    bit loading;
    bit done;
    int count;
    bit err;
    bit we;
    int addr;
    int wdata;
  } mstate_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  insn_encoder_if #(.ADDR_W(8)) bus8 ();
  insn_encoder_if #(.ADDR_W(2)) bus2 ();

  insn_encoder #(.ADDR_W(8)) u_dut8 (.i_clk(clk), .i_rst(rst), .bus(bus8));
  insn_encoder #(.ADDR_W(2)) u_dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int start, input int valid, input int typ, input int op,
                       input int rg, input int imm);
    bus8.start = 1'(start);   bus2.start = 1'(start);
    bus8.in_valid = 1'(valid); bus2.in_valid = 1'(valid);
    bus8.in_type = 2'(typ);   bus2.in_type = 2'(typ);
    bus8.in_op = 4'(op);      bus2.in_op = 4'(op);
    bus8.in_reg = 3'(rg);     bus2.in_reg = 3'(rg);
    bus8.in_imm = 5'(imm);    bus2.in_imm = 5'(imm);
  endtask

  task automatic chk8(input string t, input int we, input int addr, input int wdata,
                      input int cnt, input int done, input int rdy, input int err);
    check({t, ".we8"},    32'(bus8.mem_we), we);
    check({t, ".addr8"},  32'(bus8.mem_addr), addr);
    check({t, ".wdata8"}, 32'(bus8.mem_wdata), wdata);
    check({t, ".count8"}, 32'(bus8.count), cnt);
    check({t, ".done8"},  32'(bus8.done), done);
    check({t, ".ready8"}, 32'(bus8.in_ready), rdy);
    check({t, ".err8"},   32'(bus8.err), err);
  endtask

  task automatic chk2(input string t, input int we, input int addr, input int wdata,
                      input int cnt, input int done, input int rdy, input int err);
    check({t, ".we2"},    32'(bus2.mem_we), we);
    check({t, ".addr2"},  32'(bus2.mem_addr), addr);
    check({t, ".wdata2"}, 32'(bus2.mem_wdata), wdata);
    check({t, ".count2"}, 32'(bus2.count), cnt);
    check({t, ".done2"},  32'(bus2.done), done);
    check({t, ".ready2"}, 32'(bus2.in_ready), rdy);
    check({t, ".err2"},   32'(bus2.err), err);
  endtask

  // Instruction word as a weighted sum of the fields each class keeps
  function automatic int pack_word(int typ, int op, int rg, int imm);
    case (typ)
      0:       return typ * 128 + op * 8 + rg;
      2:       return typ * 128 + (op % 4) * 32 + imm;
      default: return typ * 128 + (op % 2) * 64 + (imm % 8) * 8 + rg;
    endcase
  endfunction

  function automatic bit field_bad(int typ, int op, int rg, int imm);
    case (typ)
      0:       return imm != 0;
      2:       return op > 3 || rg != 0;
      default: return op > 1 || imm > 7;
    endcase
  endfunction

  function automatic mstate_t model_step(mstate_t s, bit r, bit start, bit valid,
                                         int typ, int op, int rg, int imm, int depth);
    mstate_t n;
    if (r) begin
      n = '{loading: 1'b0, done: 1'b0, count: 0, err: 1'b0, we: 1'b0, addr: 0, wdata: 0};
      return n;
    end
    n = s;
    n.we = 1'b0;
    if (start) begin
      n.loading = 1'b1;
      n.done = 1'b0;
      n.count = 0;
      n.err = 1'b0;
    end else if (s.loading && valid) begin
      if (RC && field_bad(typ, op, rg, imm)) begin
        n.err = 1'b1;
      end else begin
        n.we = 1'b1;
        n.addr = s.count;
        n.wdata = pack_word(typ, op, rg, imm);
        n.count = s.count + 1;
        if ((typ == 0 && op == int'(I_HALT)) || n.count == depth) begin
          n.loading = 1'b0;
          n.done = 1'b1;
        end
      end
    end
    return n;
  endfunction

  vec_t    tbl[17];
  mstate_t m8, m2;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    //           rst st vl ty op rg imm   we ad  wd  cnt dn rd er
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0,    0, 0, 0,   0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0,    0, 0, 0,   0, 0, 1, 0};
    tbl[2]  = '{0, 0, 1, 2, 1, 0, 19,   1, 0, 307, 1, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0,    0, 0, 307, 1, 0, 1, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 0, 0,    0, 0, 307, 0, 0, 1, 0};
    tbl[5]  = '{0, 0, 1, 0, 3, 5, 0,    1, 0, 29,  1, 0, 1, 0};
    tbl[6]  = '{0, 0, 1, 1, 1, 2, 5,    1, 1, 234, 2, 0, 1, 0};
    tbl[7]  = '{0, 0, 1, 0, 15, 0, 0,   1, 2, 120, 3, 1, 0, 0};
    tbl[8]  = '{0, 0, 1, 0, 3, 5, 0,    0, 2, 120, 3, 1, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 0, 0, 0,    0, 2, 120, 0, 0, 1, 0};
    tbl[10] = '{0, 0, 1, 3, 0, 1, 3,    1, 0, 409, 1, 0, 1, 0};
    tbl[11] = '{0, 1, 1, 2, 2, 0, 4,    0, 0, 409, 0, 0, 1, 0};
    tbl[12] = '{0, 0, 1, 2, 2, 0, 4,    1, 0, 324, 1, 0, 1, 0};
    if (RC) begin
      tbl[13] = '{0, 0, 1, 1, 0, 0, 9,  0, 0, 324, 1, 0, 1, 1};
      tbl[14] = '{0, 0, 1, 1, 1, 3, 2,  1, 1, 211, 2, 0, 1, 1};
    end else begin
      tbl[13] = '{0, 0, 1, 1, 0, 0, 9,  1, 1, 136, 2, 0, 1, 0};
      tbl[14] = '{0, 0, 1, 1, 1, 3, 2,  1, 2, 211, 3, 0, 1, 0};
    end
    tbl[15] = '{1, 0, 1, 0, 1, 0, 0,    0, 0, 0,   0, 0, 0, 0};
    tbl[16] = '{0, 0, 1, 0, 1, 0, 0,    0, 0, 0,   0, 0, 0, 0};

    for (int i = 0; i < 17; i++) begin
      rst = 1'(tbl[i].rst);
      drive(tbl[i].start, tbl[i].valid, tbl[i].typ, tbl[i].op, tbl[i].rg, tbl[i].imm);
      tick();
      chk8($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata,
           tbl[i].cnt, tbl[i].done, tbl[i].rdy, tbl[i].err);
    end

    // Four-word memory fills exactly, finishes on the last address, never wraps
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 2, 0, 0, k + 1);
      tick();
      chk2($sformatf("fill%0d", k), 1, k, 256 + k + 1, k + 1,
           (k == 3) ? 1 : 0, (k == 3) ? 0 : 1, 0);
    end
    drive(0, 1, 2, 0, 0, 7);
    tick();
    chk2("fill_after", 0, 3, 260, 4, 1, 0, 0);

    // Randomized traffic on both instances against the model
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    m8 = model_step(m8, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 256);
    m2 = model_step(m2, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 4);
    rst = 1'b0;
    for (int c = 0; c < 800; c++) begin
      bit r_r, r_s, r_v;
      int typ, op, rg, imm;
      r_r = ($urandom_range(0, 99) == 0);
      r_s = ($urandom_range(0, 15) == 0);
      r_v = ($urandom_range(0, 3) != 0);
      typ = int'($urandom_range(0, 3));
      op  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1));
      rg  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : 0;
      imm = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        typ = 0;
        op = int'(I_HALT);
      end
      rst = r_r;
      drive(int'(r_s), int'(r_v), typ, op, rg, imm);
      tick();
      m8 = model_step(m8, r_r, r_s, r_v, typ, op, rg, imm, 256);
      m2 = model_step(m2, r_r, r_s, r_v, typ, op, rg, imm, 4);
      chk8($sformatf("rnd%0d", c), int'(m8.we), m8.addr, m8.wdata, m8.count,
           int'(m8.done), int'(m8.loading), int'(m8.err));
      chk2($sformatf("rnd%0d", c), int'(m2.we), m2.addr, m2.wdata, m2.count,
           int'(m2.done), int'(m2.loading), int'(m2.err));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
